// File: rtl/cnn_pkg.sv
// Shared types and image constants for the CNN frame sequencer.
// Used by cnn_frame_ctrl, its interface and its watchdog.
package cnn_pkg;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int IMG_BYTES_DEF = 98;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_SEND,
    S_WAIT_TX,
    S_CLEAR
  } frame_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cnn_frame_ctrl_if.sv
// Handshake bundle between cnn_frame_ctrl and the UART/RAM/core side.
// CNN_FRAME_CTRL_STATS_EN adds the frames_ok/frames_err counters.
interface cnn_frame_ctrl_if;
  import cnn_pkg::*;

  logic       rx_rdy;
  logic       core_res_vld;
  logic [7:0] core_result;
  logic       tx_done;
  logic       load_en;
  logic       core_en;
  logic       trmt;
  logic [7:0] tx_data;
  logic       frame_clr;
  logic       busy;
  logic       err_timeout;
  logic       err_overrun;

`ifdef CNN_FRAME_CTRL_STATS_EN
  logic [15:0] frames_ok;
  logic [15:0] frames_err;

  modport master (
    input  rx_rdy, core_res_vld, core_result, tx_done,
    output load_en, core_en, trmt, tx_data, frame_clr,
    output busy, err_timeout, err_overrun,
    output frames_ok, frames_err
  );

  modport slave (
    output rx_rdy, core_res_vld, core_result, tx_done,
    input  load_en, core_en, trmt, tx_data, frame_clr,
    input  busy, err_timeout, err_overrun,
    input  frames_ok, frames_err
  );
`else
  modport master (
    input  rx_rdy, core_res_vld, core_result, tx_done,
    output load_en, core_en, trmt, tx_data, frame_clr,
    output busy, err_timeout, err_overrun
  );

  modport slave (
    output rx_rdy, core_res_vld, core_result, tx_done,
    input  load_en, core_en, trmt, tx_data, frame_clr,
    input  busy, err_timeout, err_overrun
  );
`endif

endinterface

// File: rtl/cnn_wdog.sv
// Inter-byte watchdog: counts enabled cycles without a kick and
// pulses expire on the cycle the count sits at TIMEOUT_CYC-1.
module cnn_wdog
  import cnn_pkg::*;
#(
  parameter int CNT_W       = 20,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // a kick in the same cycle always beats expiry
  assign expire = en & ~kick & (cnt == LIM);

  always_ff @(posedge clk) begin
    if (rst || kick || expire) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cnn_frame_ctrl.sv
// Frame sequencer: load 98 bytes, capture result, transmit, clear.
// Optional stats counters under CNN_FRAME_CTRL_STATS_EN.
module cnn_frame_ctrl
  import cnn_pkg::*;
#(
  parameter int IMG_BYTES   = IMG_BYTES_DEF,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 20
) (
  input logic             clk,
  input logic             rst,
  cnn_frame_ctrl_if.master bus
);

  localparam int BW = $clog2(IMG_BYTES + 1);
  localparam logic [BW-1:0] LAST = BW'(IMG_BYTES);

  frame_state_t state, state_nxt;

  logic [BW-1:0] byte_cnt;
  logic [BW-1:0] cnt_inc;
  logic          res_held;
  logic [7:0]    tx_data_q;
  logic          err_to_q;
  logic          err_ov_q;
  logic          wd_en;
  logic          kick;
  logic          expire;
  logic          load_en;
  logic          core_en;
  logic          trmt;
  logic          frame_clr;
  logic          busy;

  assign cnt_inc = byte_cnt + 1'b1;
  assign wd_en   = (state == S_LOAD);
  assign kick    = bus.rx_rdy | ~wd_en;

  cnn_wdog #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .kick  (kick),
    .en    (wd_en),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    core_en   = 1'b0;
    trmt      = 1'b0;
    frame_clr = 1'b0;
    busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        load_en = 1'b1;
        busy    = 1'b0;
        if (bus.rx_rdy)
          state_nxt = (IMG_BYTES == 1) ? S_COMPUTE : S_LOAD;
      end
      S_LOAD: begin
        load_en = 1'b1;
        core_en = 1'b1;
        if (bus.rx_rdy && cnt_inc == LAST) state_nxt = S_COMPUTE;
        else if (expire)                   state_nxt = S_CLEAR;
      end
      S_COMPUTE: begin
        core_en = 1'b1;
        if (res_held) state_nxt = S_SEND;
      end
      S_SEND: begin
        trmt      = 1'b1;
        state_nxt = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (bus.tx_done) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        frame_clr = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt  <= '0;
      res_held  <= 1'b0;
      tx_data_q <= 8'h00;
      err_to_q  <= 1'b0;
      err_ov_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.rx_rdy) begin
            byte_cnt <= BW'(1);
            err_to_q <= 1'b0;
            err_ov_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (bus.rx_rdy) byte_cnt <= cnt_inc;
          if (expire)     err_to_q <= 1'b1;
        end
        S_CLEAR: begin
          byte_cnt <= '0;
          res_held <= 1'b0;
        end
        default: ;
      endcase
      if (bus.rx_rdy && (state inside {S_COMPUTE, S_SEND, S_WAIT_TX, S_CLEAR}))
        err_ov_q <= 1'b1;
      // first result of the frame wins until CLEAR
      if (bus.core_res_vld && !res_held && (state inside {S_LOAD, S_COMPUTE})) begin
        tx_data_q <= bus.core_result;
        res_held  <= 1'b1;
      end
    end
  end

  assign bus.load_en     = load_en;
  assign bus.core_en     = core_en;
  assign bus.trmt        = trmt;
  assign bus.frame_clr   = frame_clr;
  assign bus.busy        = busy;
  assign bus.tx_data     = tx_data_q;
  assign bus.err_timeout = err_to_q;
  assign bus.err_overrun = err_ov_q;

`ifdef CNN_FRAME_CTRL_STATS_EN
  logic [15:0] ok_q;
  logic [15:0] er_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ok_q <= '0;
      er_q <= '0;
    end else begin
      if (state == S_SEND) ok_q <= sat_inc16(ok_q);
      if (expire)          er_q <= sat_inc16(er_q);
    end
  end

  assign bus.frames_ok  = ok_q;
  assign bus.frames_err = er_q;
`endif

endmodule

// File: tb/tb_cnn_frame_ctrl.sv
// Randomized self-checking bench for cnn_frame_ctrl.
// Frame outcomes are predicted from frame-level rules, not RTL state.
module tb_cnn_frame_ctrl;

  localparam int TO = 100;
  localparam int NB = 98;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int trmt_cnt = 0;
  int clr_cnt = 0;

  cnn_frame_ctrl_if bus();

  cnn_frame_ctrl #(
    .IMG_BYTES  (NB),
    .TIMEOUT_CYC(TO),
    .CNT_W      (20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.trmt === 1'b1)      trmt_cnt <= trmt_cnt + 1;
    if (bus.frame_clr === 1'b1) clr_cnt  <= clr_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input int n, input int gmin, input int gmax,
                             input int ra, input logic [7:0] rv,
                             input int ra2, input logic [7:0] rv2);
    for (int i = 1; i <= n; i++) begin
      bus.rx_rdy = 1'b1;
      if (i == ra) begin
        bus.core_res_vld = 1'b1;
        bus.core_result  = rv;
      end else if (i == ra2) begin
        bus.core_res_vld = 1'b1;
        bus.core_result  = rv2;
      end
      cyc(1);
      bus.rx_rdy       = 1'b0;
      bus.core_res_vld = 1'b0;
      bus.core_result  = 8'($urandom);
      if (i < n) cyc(int'($urandom_range(gmax, gmin)) - 1);
    end
  endtask

  task automatic pulse_result(input logic [7:0] v);
    bus.core_res_vld = 1'b1;
    bus.core_result  = v;
    cyc(1);
    bus.core_res_vld = 1'b0;
  endtask

  task automatic wait_trmt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (bus.trmt === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic tx_handshake(input int d);
    cyc(d);
    bus.tx_done = 1'b1;
    cyc(1);
    bus.tx_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] v;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    v = {bus.load_en, bus.core_en, bus.trmt, bus.frame_clr,
         bus.busy, bus.err_timeout, bus.err_overrun};
    checks++;
    if (v !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_outs: got %b exp %b", v, 7'b1000000);
    end
    checks++;
    if (bus.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx_data: got %h exp 00", bus.tx_data);
    end
  endtask

  task automatic test_nominal();
    int t0, c0;
    bit ok;
    logic [2:0] v;
    t0 = trmt_cnt;
    c0 = clr_cnt;
    drive_frame(1, 10, 10, 0, 8'h00, 0, 8'h00);
    @(negedge clk);
    v = {bus.load_en, bus.core_en, bus.busy};
    checks++;
    if (v !== 3'b111) begin
      errors++;
      $display("FAIL nom_load_outs: got %b exp 111", v);
    end
    cyc(9);
    drive_frame(NB - 1, 10, 10, 0, 8'h00, 0, 8'h00);
    @(negedge clk);
    v = {bus.load_en, bus.core_en, bus.trmt};
    checks++;
    if (v !== 3'b010) begin
      errors++;
      $display("FAIL nom_compute_outs: got %b exp 010", v);
    end
    pulse_result(8'h07);
    wait_trmt(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL nom_trmt: got none exp pulse");
    end
    checks++;
    if (bus.tx_data !== 8'h07) begin
      errors++;
      $display("FAIL nom_tx_data: got %h exp 07", bus.tx_data);
    end
    tx_handshake(20);
    @(negedge clk);
    checks++;
    if (bus.frame_clr !== 1'b1 || bus.tx_data !== 8'h07) begin
      errors++;
      $display("FAIL nom_clr: got clr=%b data=%h exp 1/07",
               bus.frame_clr, bus.tx_data);
    end
    @(negedge clk);
    v = {bus.busy, bus.err_timeout, bus.err_overrun};
    checks++;
    if (v !== 3'b000 || bus.load_en !== 1'b1) begin
      errors++;
      $display("FAIL nom_idle: got busy/err=%b load=%b exp 000/1",
               v, bus.load_en);
    end
    checks++;
    if (trmt_cnt - t0 != 1 || clr_cnt - c0 != 1) begin
      errors++;
      $display("FAIL nom_pulses: got trmt=%0d clr=%0d exp 1/1",
               trmt_cnt - t0, clr_cnt - c0);
    end
  endtask

  task automatic test_early_result();
    int t0;
    bit ok;
    t0 = trmt_cnt;
    drive_frame(NB - 1, 1, 6, 50, 8'h03, 60, 8'h05);
    @(negedge clk);
    checks++;
    if (trmt_cnt != t0 || bus.load_en !== 1'b1) begin
      errors++;
      $display("FAIL early_no_trmt: got trmt=%0d load=%b exp 0/1",
               trmt_cnt - t0, bus.load_en);
    end
    drive_frame(1, 1, 1, 0, 8'h00, 0, 8'h00);
    pulse_result(8'h09);
    wait_trmt(ok);
    checks++;
    if (!ok || bus.tx_data !== 8'h03) begin
      errors++;
      $display("FAIL early_tx_data: got ok=%b data=%h exp 1/03",
               ok, bus.tx_data);
    end
    tx_handshake($urandom_range(20, 1));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (trmt_cnt - t0 != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL early_done: got trmt=%0d busy=%b exp 1/0",
               trmt_cnt - t0, bus.busy);
    end
  endtask

  task automatic test_timeout();
    int t0, hit;
    bit ok;
    logic eb;
    t0 = trmt_cnt;
    hit = 0;
    eb = 1'bx;
    drive_frame(40, 1, 5, 0, 8'h00, 0, 8'h00);
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      if (bus.frame_clr === 1'b1 && hit == 0) hit = k;
      if (k == TO) eb = bus.err_timeout;
    end
    checks++;
    if (hit != TO + 1) begin
      errors++;
      $display("FAIL to_clr_cycle: got %0d exp %0d", hit, TO + 1);
    end
    checks++;
    if (bus.err_timeout !== 1'b1 || eb !== 1'b0) begin
      errors++;
      $display("FAIL to_err: got %b before=%b exp 1/0",
               bus.err_timeout, eb);
    end
    @(negedge clk);
    checks++;
    if (trmt_cnt != t0 || bus.busy !== 1'b0 || bus.err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_abort: got trmt=%0d busy=%b err=%b exp 0/0/1",
               trmt_cnt - t0, bus.busy, bus.err_timeout);
    end
    bus.rx_rdy = 1'b1;
    cyc(1);
    bus.rx_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.err_timeout !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL to_err_clear: got err=%b busy=%b exp 0/1",
               bus.err_timeout, bus.busy);
    end
    cyc(TO - 1);
    drive_frame(4, TO, TO, 0, 8'h00, 0, 8'h00);
    @(negedge clk);
    checks++;
    if (bus.err_timeout !== 1'b0 || bus.load_en !== 1'b1) begin
      errors++;
      $display("FAIL to_boundary: got err=%b load=%b exp 0/1",
               bus.err_timeout, bus.load_en);
    end
    drive_frame(NB - 5, 1, 3, 10, 8'h6E, 0, 8'h00);
    wait_trmt(ok);
    checks++;
    if (!ok || bus.tx_data !== 8'h6E) begin
      errors++;
      $display("FAIL to_next_frame: got ok=%b data=%h exp 1/6e",
               ok, bus.tx_data);
    end
    tx_handshake(3);
    cyc(2);
  endtask

  task automatic test_overrun();
    bit ok;
    logic [3:0] v;
    drive_frame(NB, 1, 4, 0, 8'h00, 0, 8'h00);
    cyc(2);
    bus.rx_rdy = 1'b1;
    cyc(1);
    bus.rx_rdy = 1'b0;
    @(negedge clk);
    v = {bus.err_overrun, bus.load_en, bus.core_en, bus.busy};
    checks++;
    if (v !== 4'b1011) begin
      errors++;
      $display("FAIL ov_flag: got %b exp 1011", v);
    end
    pulse_result(8'hA5);
    wait_trmt(ok);
    checks++;
    if (!ok || bus.tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL ov_tx_data: got ok=%b data=%h exp 1/a5",
               ok, bus.tx_data);
    end
    tx_handshake(5);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.err_overrun !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ov_sticky: got err=%b busy=%b exp 1/0",
               bus.err_overrun, bus.busy);
    end
    drive_frame(1, 1, 1, 0, 8'h00, 0, 8'h00);
    @(negedge clk);
    checks++;
    if (bus.err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ov_clear: got %b exp 0", bus.err_overrun);
    end
    drive_frame(NB - 1, 1, 2, 7, 8'h3C, 0, 8'h00);
    wait_trmt(ok);
    checks++;
    if (!ok || bus.tx_data !== 8'h3C) begin
      errors++;
      $display("FAIL ov_next: got ok=%b data=%h exp 1/3c", ok, bus.tx_data);
    end
    tx_handshake(2);
    cyc(2);
  endtask

  task automatic test_reset_mid();
    int c0;
    bit ok;
    logic [6:0] v;
    drive_frame(NB, 1, 3, 20, 8'h5A, 0, 8'h00);
    wait_trmt(ok);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    c0 = clr_cnt;
    @(negedge clk);
    v = {bus.load_en, bus.core_en, bus.trmt, bus.frame_clr,
         bus.busy, bus.err_timeout, bus.err_overrun};
    checks++;
    if (!ok || v !== 7'b1000000 || bus.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_outs: got ok=%b %b data=%h exp 1/1000000/00",
               ok, v, bus.tx_data);
    end
    cyc(5);
    checks++;
    if (clr_cnt != c0) begin
      errors++;
      $display("FAIL rstmid_no_clr: got %0d exp 0", clr_cnt - c0);
    end
    drive_frame(NB, 1, 3, 0, 8'h00, 0, 8'h00);
    pulse_result(8'hC3);
    wait_trmt(ok);
    checks++;
    if (!ok || bus.tx_data !== 8'hC3) begin
      errors++;
      $display("FAIL rstmid_frame: got ok=%b data=%h exp 1/c3",
               ok, bus.tx_data);
    end
    tx_handshake(4);
    @(negedge clk);
    checks++;
    if (bus.frame_clr !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_clr: got %b exp 1", bus.frame_clr);
    end
    cyc(2);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int ra = int'($urandom_range(NB, 0));
      int ra2 = (ra != 0 && ra < NB) ? ra + 1 : 0;
      logic [7:0] rv = 8'($urandom);
      logic [7:0] rv2 = ~rv;
      int t0 = trmt_cnt;
      int c0 = clr_cnt;
      bit ok;
      drive_frame(NB, 1, 12, ra, rv, ra2, rv2);
      if (ra == 0) begin
        cyc($urandom_range(4, 0));
        pulse_result(rv);
      end
      wait_trmt(ok);
      checks++;
      if (!ok || bus.tx_data !== rv) begin
        errors++;
        $display("FAIL rnd%0d_tx_data: got ok=%b data=%h exp 1/%h",
                 f, ok, bus.tx_data, rv);
      end
      tx_handshake($urandom_range(20, 1));
      @(negedge clk);
      checks++;
      if (bus.frame_clr !== 1'b1) begin
        errors++;
        $display("FAIL rnd%0d_clr: got %b exp 1", f, bus.frame_clr);
      end
      @(negedge clk);
      checks++;
      if (trmt_cnt - t0 != 1 || clr_cnt - c0 != 1 || bus.busy !== 1'b0 ||
          bus.err_timeout !== 1'b0 || bus.err_overrun !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_end: got trmt=%0d clr=%0d busy=%b err=%b%b exp 1/1/0/00",
                 f, trmt_cnt - t0, clr_cnt - c0, bus.busy,
                 bus.err_timeout, bus.err_overrun);
      end
    end
  endtask

`ifdef CNN_FRAME_CTRL_STATS_EN
  task automatic test_stats();
    bit ok;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.frames_ok !== 16'd0 || bus.frames_err !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset: got %0d/%0d exp 0/0",
               bus.frames_ok, bus.frames_err);
    end
    for (int i = 0; i < 2; i++) begin
      drive_frame(NB, 1, 2, 1, 8'h11, 0, 8'h00);
      wait_trmt(ok);
      tx_handshake(2);
      cyc(2);
    end
    drive_frame(3, 1, 1, 0, 8'h00, 0, 8'h00);
    cyc(TO + 5);
    @(negedge clk);
    checks++;
    if (bus.frames_ok !== 16'd2 || bus.frames_err !== 16'd1) begin
      errors++;
      $display("FAIL stats_counts: got %0d/%0d exp 2/1",
               bus.frames_ok, bus.frames_err);
    end
  endtask
`endif

  initial begin
    bus.rx_rdy       = 1'b0;
    bus.core_res_vld = 1'b0;
    bus.core_result  = 8'h00;
    bus.tx_done      = 1'b0;
    test_reset();
    test_nominal();
    test_early_result();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_random();
`ifdef CNN_FRAME_CTRL_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
